// File: rtl/character_jump_controller.sv
// character_jump_controller
//
// Frame-stepped jump/gravity sequencer for the player character in a
// 160x120 pixel space, where y grows downward. Motion advances only on
// frame ticks (enable). A jump request is a rising edge of the debounced
// jump button that is seen while the character is on the ground.
//
// Optional build macro:
//   VARIABLE_JUMP_EN - if jump is low on a rising tick, the upward motion is
//                      cut short and the character starts falling (short hop).
//
// Ports:
//   clock      in   system clock; all state changes on its rising edge
//   resetn     in   synchronous active-low reset
//   enable     in   frame tick, a one-cycle pulse per frame
//   jump       in   debounced jump button, active high, level
//   x_position out  [7:0] character x, constant CHAR_X
//   y_position out  [6:0] character y, registered
//   airborne   out  high while RISING or FALLING
//   landed     out  one-clock pulse after the landing step
//   dbg_state  out  [1:0] current FSM state (0 grounded, 1 rising, 2 falling)
//
// Handshake: there is no valid/ready pair. enable is a qualifier that is
// sampled on every rising clock edge, and the result of an enabled step
// shows on the outputs after that edge. No input reaches an output
// combinationally.
module character_jump_controller #(
  parameter logic [7:0] CHAR_X    = 8'd72,
  parameter logic [6:0] GROUND_Y  = 7'd60,
  parameter logic [6:0] CEILING_Y = 7'd0,
  parameter logic [3:0] JUMP_VEL  = 4'd6,
  parameter logic [3:0] GRAVITY   = 4'd1,
  parameter logic [3:0] MAX_FALL  = 4'd6
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       enable,
  input  logic       jump,
  output logic [7:0] x_position,
  output logic [6:0] y_position,
  output logic       airborne,
  output logic       landed,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_GROUNDED = 2'd0,
    ST_RISING   = 2'd1,
    ST_FALLING  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [6:0] y_q, y_d;
  logic [3:0] speed_q, speed_d;
  logic       pending_q, pending_d;
  logic       jump_prev_q, jump_prev_d;
  logic       landed_q, landed_d;

  logic       jump_edge;
  logic [7:0] y_ext;
  logic [7:0] speed_ext;
  logic [7:0] ceil_lim;
  logic [6:0] rise_ny;
  logic [7:0] fall_sum;
  logic [7:0] fall_ns;
  logic [7:0] fall_ny;

  // All intermediate sums are 8 bits wide, so y cannot wrap past 0 or 127.
  always_comb begin
    jump_edge = jump & ~jump_prev_q;
    y_ext     = {1'b0, y_q};
    speed_ext = {4'b0000, speed_q};
    ceil_lim  = {1'b0, CEILING_Y} + speed_ext;
    // This value is used only when y >= CEILING_Y + speed, so it cannot underflow.
    rise_ny   = y_q - {3'b000, speed_q};
    fall_sum  = speed_ext + {4'b0000, GRAVITY};
    fall_ns   = (fall_sum > {4'b0000, MAX_FALL}) ? {4'b0000, MAX_FALL} : fall_sum;
    fall_ny   = y_ext + fall_ns;
  end

  always_comb begin
    state_d     = state_q;
    y_d         = y_q;
    speed_d     = speed_q;
    pending_d   = pending_q;
    landed_d    = 1'b0;
    jump_prev_d = jump;

    case (state_q)
      ST_GROUNDED: begin
        y_d = GROUND_Y;
        // An edge that arrives on the same cycle as enable launches at once.
        if (enable && (pending_q || jump_edge)) begin
          speed_d   = JUMP_VEL;
          state_d   = ST_RISING;
          pending_d = 1'b0;
        end else if (jump_edge) begin
          pending_d = 1'b1;
        end
      end

      ST_RISING: begin
        // Edges seen while airborne are discarded.
        pending_d = 1'b0;
        if (enable) begin
          if (y_ext < ceil_lim) begin
            y_d     = CEILING_Y;
            speed_d = 4'd0;
            state_d = ST_FALLING;
          end else begin
            y_d = rise_ny;
            if (speed_q <= GRAVITY) begin
              speed_d = 4'd0;
              state_d = ST_FALLING;
            end else begin
              speed_d = speed_q - GRAVITY;
            end
          end
`ifdef VARIABLE_JUMP_EN
          // Releasing the button cuts the rise. y has already taken this step.
          if (!jump) begin
            speed_d = 4'd0;
            state_d = ST_FALLING;
          end
`endif
        end
      end

      ST_FALLING: begin
        pending_d = 1'b0;
        if (enable) begin
          if (fall_ny >= {1'b0, GROUND_Y}) begin
            y_d      = GROUND_Y;
            speed_d  = 4'd0;
            state_d  = ST_GROUNDED;
            landed_d = 1'b1;
          end else begin
            y_d     = fall_ny[6:0];
            speed_d = fall_ns[3:0];
          end
        end
      end

      default: begin
        // An illegal encoding recovers to the ground without waiting for a tick.
        state_d   = ST_GROUNDED;
        y_d       = GROUND_Y;
        speed_d   = 4'd0;
        pending_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= ST_GROUNDED;
      y_q         <= GROUND_Y;
      speed_q     <= 4'd0;
      pending_q   <= 1'b0;
      jump_prev_q <= 1'b0;
      landed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      speed_q     <= speed_d;
      pending_q   <= pending_d;
      jump_prev_q <= jump_prev_d;
      landed_q    <= landed_d;
    end
  end

  assign x_position = CHAR_X;
  assign y_position = y_q;
  assign airborne   = (state_q == ST_RISING) || (state_q == ST_FALLING);
  assign landed     = landed_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_character_jump_controller.sv
// tb_character_jump_controller
//
// Directed bench for character_jump_controller. The main instance uses the
// default parameters. A second instance (CEILING_Y=50, JUMP_VEL=15) shares
// the same inputs and is checked only during the ceiling sequence.
// Every expected value is hand-computed from the jump/gravity rules.
module tb_character_jump_controller;

  // Clock and reset.
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic resetn;
  logic enable;
  logic jump;

  logic [7:0] x_main, x_ceil;
  logic [6:0] y_main, y_ceil;
  logic       air_main, air_ceil;
  logic       land_main, land_ceil;
  logic [1:0] st_main, st_ceil;

  character_jump_controller u_dut (
    .clock      (clock),
    .resetn     (resetn),
    .enable     (enable),
    .jump       (jump),
    .x_position (x_main),
    .y_position (y_main),
    .airborne   (air_main),
    .landed     (land_main),
    .dbg_state  (st_main)
  );

  character_jump_controller #(
    .CEILING_Y (7'd50),
    .JUMP_VEL  (4'd15)
  ) u_ceil (
    .clock      (clock),
    .resetn     (resetn),
    .enable     (enable),
    .jump       (jump),
    .x_position (x_ceil),
    .y_position (y_ceil),
    .airborne   (air_ceil),
    .landed     (land_ceil),
    .dbg_state  (st_ceil)
  );

  localparam logic [1:0] G = 2'd0;
  localparam logic [1:0] R = 2'd1;
  localparam logic [1:0] F = 2'd2;

  typedef struct {
    logic       en;
    logic       jp;
    logic [6:0] y;
    logic       air;
    logic       land;
    logic [1:0] st;
  } vec_t;

  vec_t vecs[$];

  int checks = 0;
  int errors = 0;

  // Scoreboard helpers.
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic check_main(input string tag, input logic [6:0] y, input logic air,
                            input logic land, input logic [1:0] st);
    check({tag, "_y"},    {1'b0, y_main},    {1'b0, y});
    check({tag, "_air"},  {7'b0, air_main},  {7'b0, air});
    check({tag, "_land"}, {7'b0, land_main}, {7'b0, land});
    check({tag, "_st"},   {6'b0, st_main},   {6'b0, st});
    check({tag, "_x"},    x_main,            8'd72);
  endtask

  task automatic check_ceil(input string tag, input logic [6:0] y, input logic air,
                            input logic land, input logic [1:0] st);
    check({tag, "_y"},    {1'b0, y_ceil},    {1'b0, y});
    check({tag, "_air"},  {7'b0, air_ceil},  {7'b0, air});
    check({tag, "_land"}, {7'b0, land_ceil}, {7'b0, land});
    check({tag, "_st"},   {6'b0, st_ceil},   {6'b0, st});
  endtask

  // Driver tasks: inputs change on the falling edge and outputs are sampled 1 ns after the rising edge.
  task automatic step(input logic en, input logic jp);
    @(negedge clock);
    resetn = 1'b1;
    enable = en;
    jump   = jp;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0;
    enable = 1'b0;
    jump   = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic add(input logic en, input logic jp, input logic [6:0] y,
                     input logic air, input logic land, input logic [1:0] st);
    vecs.push_back('{en: en, jp: jp, y: y, air: air, land: land, st: st});
  endtask

  initial begin
    resetn = 1'b0;
    enable = 1'b0;
    jump   = 1'b0;

    // First jump, with the button held through the landing.
    add(0, 1, 60, 0, 0, G);  // edge without tick -> pending
    add(1, 1, 60, 1, 0, R);  // launch tick, y unchanged
    add(1, 1, 54, 1, 0, R);
    add(1, 1, 49, 1, 0, R);
    add(0, 1, 49, 1, 0, R);  // no tick -> hold
    add(1, 1, 45, 1, 0, R);
    add(1, 1, 42, 1, 0, R);
    add(1, 1, 40, 1, 0, R);
    add(1, 1, 39, 1, 0, F);
    add(1, 1, 40, 1, 0, F);
    add(1, 1, 42, 1, 0, F);
    add(1, 1, 45, 1, 0, F);
    add(1, 1, 49, 1, 0, F);
    add(1, 1, 54, 1, 0, F);
    add(1, 1, 60, 0, 1, G);  // landing step
    add(0, 1, 60, 0, 0, G);  // landed is a single pulse
    for (int i = 0; i < 5; i++) add(1, 1, 60, 0, 0, G);  // held -> no relaunch
    add(1, 0, 60, 0, 0, G);  // release
    // Second jump: edge on the same cycle as the tick, then an edge while airborne.
    add(1, 1, 60, 1, 0, R);
    add(1, 1, 54, 1, 0, R);
    add(1, 1, 49, 1, 0, R);
    add(1, 1, 45, 1, 0, R);
    add(0, 0, 45, 1, 0, R);
    add(0, 1, 45, 1, 0, R);  // airborne edge, discarded
    add(1, 1, 42, 1, 0, R);
    add(1, 1, 40, 1, 0, R);
    add(1, 1, 39, 1, 0, F);
    add(1, 1, 40, 1, 0, F);
    add(1, 1, 42, 1, 0, F);
    add(1, 1, 45, 1, 0, F);
    add(1, 1, 49, 1, 0, F);
    add(1, 1, 54, 1, 0, F);
    add(1, 1, 60, 0, 1, G);
    add(1, 1, 60, 0, 0, G);  // no relaunch from the airborne edge
    add(1, 1, 60, 0, 0, G);
    // Pending request survives release of the button before the tick.
    add(0, 0, 60, 0, 0, G);
    add(0, 1, 60, 0, 0, G);
    add(0, 0, 60, 0, 0, G);
    add(1, 0, 60, 1, 0, R);
    add(1, 1, 54, 1, 0, R);
    add(1, 1, 49, 1, 0, R);
    add(1, 1, 45, 1, 0, R);
    add(1, 1, 42, 1, 0, R);

    // Reset state, then idle ticks.
    do_reset();
    check_main("reset", 60, 0, 0, G);
    for (int i = 0; i < 10; i++) begin
      step(1, 0);
      check_main($sformatf("idle%0d", i), 60, 0, 0, G);
    end

    // Table-driven vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].en, vecs[i].jp);
      check_main($sformatf("vec%0d", i), vecs[i].y, vecs[i].air, vecs[i].land, vecs[i].st);
    end

    // Reset in the middle of a rise (y=42).
    do_reset();
    check_main("midrise_rst", 60, 0, 0, G);
    step(1, 0);
    check_main("midrise_after", 60, 0, 0, G);

    // Reset clears a pending request.
    step(0, 1);
    step(0, 0);
    do_reset();
    step(1, 0);
    check_main("pend_clr", 60, 0, 0, G);
    step(1, 0);
    check_main("pend_clr2", 60, 0, 0, G);

    // Ceiling hit on the second instance.
    do_reset();
    check_ceil("ceil_rst", 60, 0, 0, G);
    step(0, 0);
    step(1, 1);
    check_ceil("ceil_launch", 60, 1, 0, R);
    step(1, 1);
    check_ceil("ceil_hit", 50, 1, 0, F);
    step(1, 1);
    check_ceil("ceil_f1", 51, 1, 0, F);
    step(1, 1);
    check_ceil("ceil_f2", 53, 1, 0, F);
    step(1, 1);
    check_ceil("ceil_f3", 56, 1, 0, F);
    step(1, 1);
    check_ceil("ceil_land", 60, 0, 1, G);
    step(0, 0);
    check_ceil("ceil_after", 60, 0, 0, G);
    check("ceil_x", x_ceil, 8'd72);

    // Early release of the button.
    do_reset();
    step(1, 1);
    check_main("rel_launch", 60, 1, 0, R);
    step(1, 1);
    check_main("rel_54", 54, 1, 0, R);
    step(1, 0);
`ifdef VARIABLE_JUMP_EN
    check_main("rel_49", 49, 1, 0, F);
    step(1, 0);
    check_main("rel_50", 50, 1, 0, F);
    step(1, 0);
    check_main("rel_52", 52, 1, 0, F);
    step(1, 0);
    check_main("rel_55", 55, 1, 0, F);
    step(1, 0);
    check_main("rel_59", 59, 1, 0, F);
    step(1, 0);
    check_main("rel_60", 60, 0, 1, G);
`else
    check_main("rel_49", 49, 1, 0, R);
    step(1, 0);
    check_main("rel_45", 45, 1, 0, R);
    step(1, 0);
    check_main("rel_42", 42, 1, 0, R);
`endif

    // Final report.
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
